// File: rtl/ex_stage_muldiv.sv
// ex_stage_muldiv: execute stage of the 16-bit RISC pipeline.
//   Single-cycle ALU ops register their result on the accepting edge (latency 1).
//   MUL / DIVU / REMU run on a WIDTH-step sequential engine. While that engine
//   is busy, 'stall' holds the front of the pipe.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   flush                         kills the accepting / in-flight instruction
//   in_valid, alu_op, alu_src,    ID/EX control
//   reg_dst
//   addr_in, read_data_1_in,      ID/EX data
//   read_data_2_in,
//   sign_extended_immediate_in,
//   rt_in, rd_in, hit_in
//   stall                         combinational hold request to upstream
//   out_valid, alu_result_out,    EX/MEM fields (hold value when out_valid = 0)
//   store_data_out, write_reg_out,
//   addr_out, hit_out, zero_out
module ex_stage_muldiv #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned RW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [3:0]       alu_op,
  input  logic             alu_src,
  input  logic             reg_dst,
  input  logic [WIDTH-1:0] addr_in,
  input  logic [WIDTH-1:0] read_data_1_in,
  input  logic [WIDTH-1:0] read_data_2_in,
  input  logic [WIDTH-1:0] sign_extended_immediate_in,
  input  logic [RW-1:0]    rt_in,
  input  logic [RW-1:0]    rd_in,
  input  logic             hit_in,
  output logic             stall,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_result_out,
  output logic [WIDTH-1:0] store_data_out,
  output logic [RW-1:0]    write_reg_out,
  output logic [WIDTH-1:0] addr_out,
  output logic             hit_out,
  output logic             zero_out
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_DIVU = 4'd10;
  localparam logic [3:0] OP_REMU = 4'd11;

  typedef enum logic {IDLE, ITER} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      op_q;
  // Engine registers. MUL: acc = partial product, a = shifted multiplicand,
  // b = shifted multiplier. DIV: acc = partial remainder, a = dividend
  // shifting out / quotient shifting in, b = divisor.
  logic [WIDTH-1:0] acc_q, a_q, b_q;
  // Side-band fields captured at acceptance for the multi-cycle result.
  logic [WIDTH-1:0] sd_q, addr_q;
  logic [RW-1:0]    wr_q;
  logic             hit_q;

  logic [WIDTH-1:0] op_b;
  logic [RW-1:0]    wr_sel;
  logic             is_md, accept;
  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] acc_d, a_d, b_d, md_result_d;
  logic [WIDTH:0]   r_shift, r_diff;
  logic             r_ge;

  assign op_b   = alu_src ? sign_extended_immediate_in : read_data_2_in;
  assign wr_sel = reg_dst ? rd_in : rt_in;
  assign is_md  = (alu_op == OP_MUL) || (alu_op == OP_DIVU) || (alu_op == OP_REMU);
  assign accept = (state_q == IDLE) && in_valid && !flush;

  // Gated with rst_n so stall reads 0 during reset even with a muldiv op presented.
  assign stall = rst_n && ((accept && is_md) ||
                           ((state_q == ITER) && !flush && (cnt_q != CNT_LAST)));

  always_comb begin
    result_d = '0;
    case (alu_op)
      OP_ADD:  result_d = read_data_1_in + op_b;
      OP_SUB:  result_d = read_data_1_in - op_b;
      OP_AND:  result_d = read_data_1_in & op_b;
      OP_OR:   result_d = read_data_1_in | op_b;
      OP_XOR:  result_d = read_data_1_in ^ op_b;
      OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(read_data_1_in) < $signed(op_b))};
      OP_SLL:  result_d = read_data_1_in << op_b[3:0];
      OP_SRL:  result_d = read_data_1_in >> op_b[3:0];
      OP_SRA:  result_d = $unsigned($signed(read_data_1_in) >>> op_b[3:0]);
      default: result_d = op_b;
    endcase
  end

  // One engine step. Restoring division: shift the next dividend bit into the
  // remainder and subtract the divisor when it fits. A zero divisor always
  // fits, which yields quotient all-ones and remainder = dividend for free.
  always_comb begin
    r_shift     = {acc_q, a_q[WIDTH-1]};
    r_diff      = r_shift - {1'b0, b_q};
    r_ge        = !r_diff[WIDTH];
    acc_d       = acc_q;
    a_d         = a_q;
    b_d         = b_q;
    md_result_d = '0;
    if (op_q == OP_MUL) begin
      acc_d       = b_q[0] ? (acc_q + a_q) : acc_q;
      a_d         = a_q << 1;
      b_d         = b_q >> 1;
      md_result_d = acc_d;
    end else begin
      acc_d       = r_ge ? r_diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
      a_d         = {a_q[WIDTH-2:0], r_ge};
      md_result_d = (op_q == OP_DIVU) ? a_d : acc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      op_q           <= '0;
      acc_q          <= '0;
      a_q            <= '0;
      b_q            <= '0;
      sd_q           <= '0;
      addr_q         <= '0;
      wr_q           <= '0;
      hit_q          <= 1'b0;
      out_valid      <= 1'b0;
      alu_result_out <= '0;
      store_data_out <= '0;
      write_reg_out  <= '0;
      addr_out       <= '0;
      hit_out        <= 1'b0;
      zero_out       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_md) begin
              op_q    <= alu_op;
              acc_q   <= '0;
              a_q     <= read_data_1_in;
              b_q     <= op_b;
              sd_q    <= read_data_2_in;
              addr_q  <= addr_in;
              wr_q    <= wr_sel;
              hit_q   <= hit_in;
              cnt_q   <= '0;
              state_q <= ITER;
            end else begin
              out_valid      <= 1'b1;
              alu_result_out <= result_d;
              store_data_out <= read_data_2_in;
              write_reg_out  <= wr_sel;
              addr_out       <= addr_in;
              hit_out        <= hit_in;
              zero_out       <= (result_d == '0);
            end
          end
        end
        ITER: begin
          if (flush) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            a_q   <= a_d;
            b_q   <= b_d;
            if (cnt_q == CNT_LAST) begin
              cnt_q          <= '0;
              state_q        <= IDLE;
              out_valid      <= 1'b1;
              alu_result_out <= md_result_d;
              store_data_out <= sd_q;
              write_reg_out  <= wr_q;
              addr_out       <= addr_q;
              hit_out        <= hit_q;
              zero_out       <= (md_result_d == '0);
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
